// File: rtl/lms_pkg.sv
// Shared types, widths and the saturating resize for the LMS MAC/update block.
// Defining LMS_LEAK_EN selects the leaky coefficient update.
package lms_pkg;

    localparam int XW   = 8;
    localparam int WW   = 16;
    localparam int FRAC = 8;
    localparam int ACCW = XW + WW + 2;
    localparam int UPW  = XW + WW;

`ifdef LMS_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StErr,
        StUpd,
        StDone
    } state_e;

    // Clamp an accumulator-width value into the coefficient range.
    function automatic logic signed [WW-1:0] sat_ww(input logic signed [ACCW-1:0] v);
        logic signed [WW-1:0] r;
        if (v[ACCW-1:WW-1] == {(ACCW-WW+1){1'b0}} || v[ACCW-1:WW-1] == {(ACCW-WW+1){1'b1}}) begin
            r = v[WW-1:0];
        end else if (v[ACCW-1]) begin
            r = {1'b1, {(WW-1){1'b0}}};
        end else begin
            r = {1'b0, {(WW-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_sat_add.sv
// Signed add of two wide operands with the result clamped to OUTW bits.
module lms_sat_add #(
    parameter int INW  = lms_pkg::UPW,
    parameter int OUTW = lms_pkg::WW
) (
    input  logic signed [INW-1:0]  a,
    input  logic signed [INW-1:0]  b,
    output logic signed [OUTW-1:0] sum
);

    logic signed [INW:0]      full;
    logic        [INW-OUTW+1:0] hi;

    always_comb begin
        full = {a[INW-1], a} + {b[INW-1], b};
        hi   = full[INW:OUTW-1];
        if (hi == '0 || hi == '1) begin
            sum = full[OUTW-1:0];
        end else if (full[INW]) begin
            sum = {1'b1, {(OUTW-1){1'b0}}};
        end else begin
            sum = {1'b0, {(OUTW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/lms_mac_update.sv
// 4-tap LMS filter/update using one shared multiplier sequenced by a small FSM.
// Leaky update is selected at build time with LMS_LEAK_EN.
module lms_mac_update
    import lms_pkg::*;
#(
    parameter int MU_SHIFT   = 4,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [XW-1:0] x0,
    input  logic signed [XW-1:0] x1,
    input  logic signed [XW-1:0] x2,
    input  logic signed [XW-1:0] x3,
    input  logic signed [XW-1:0] d,
    input  logic                 adapt_en,
    output logic                 out_valid,
    output logic signed [WW-1:0] y,
    output logic signed [WW-1:0] e,
    output logic signed [WW-1:0] w0,
    output logic signed [WW-1:0] w1,
    output logic signed [WW-1:0] w2,
    output logic signed [WW-1:0] w3
);

    state_e state_q, state_d;
    logic [1:0]              idx_q;
    logic signed [XW-1:0]    x_q [4];
    logic signed [XW-1:0]    d_q;
    logic                    adapt_q;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [WW-1:0]    y_q, e_q;
    logic signed [WW-1:0]    w_q [4];

    logic                    accept;
    logic signed [WW-1:0]    mul_a;
    logic signed [XW-1:0]    mul_b;
    logic signed [UPW-1:0]   prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [WW-1:0]    y_new, e_new, w_new;
    logic signed [UPW-1:0]   err_a, err_b, w_ext, upd_a, upd_b;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;

    // The single multiplier takes w_idx during MAC and the error during UPD.
    always_comb begin
        mul_a    = (state_q == StUpd) ? e_q : w_q[idx_q];
        mul_b    = x_q[idx_q];
        prod     = UPW'(mul_a) * UPW'(mul_b);
        prod_ext = ACCW'(prod);
        y_new    = sat_ww(acc_q >>> FRAC);
        err_a    = UPW'(d_q);
        err_b    = -UPW'(y_new);
        w_ext    = UPW'(w_q[idx_q]);
        upd_a    = LEAK_EN ? (w_ext - (w_ext >>> LEAK_SHIFT)) : w_ext;
        upd_b    = prod >>> MU_SHIFT;
    end

    lms_sat_add #(
        .INW  (UPW),
        .OUTW (WW)
    ) u_err_add (
        .a   (err_a),
        .b   (err_b),
        .sum (e_new)
    );

    lms_sat_add #(
        .INW  (UPW),
        .OUTW (WW)
    ) u_upd_add (
        .a   (upd_a),
        .b   (upd_b),
        .sum (w_new)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (idx_q == 2'd3) state_d = StErr;
            StErr:   state_d = adapt_q ? StUpd : StDone;
            StUpd:   if (idx_q == 2'd3) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            d_q     <= '0;
            adapt_q <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            e_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        x_q[0]  <= x0;
                        x_q[1]  <= x1;
                        x_q[2]  <= x2;
                        x_q[3]  <= x3;
                        d_q     <= d;
                        adapt_q <= adapt_en;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + prod_ext;
                    idx_q <= idx_q + 2'd1;
                end
                StErr: begin
                    y_q   <= y_new;
                    e_q   <= e_new;
                    idx_q <= '0;
                end
                StUpd: begin
                    w_q[idx_q] <= w_new;
                    idx_q      <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign y  = y_q;
    assign e  = e_q;
    assign w0 = w_q[0];
    assign w1 = w_q[1];
    assign w2 = w_q[2];
    assign w3 = w_q[3];

endmodule

// File: doc/lms_mac_update.md
Name: lms_mac_update

Overview:
- Downstream consumer of the 4-tap input delay line in the LMS adaptive FIR datapath.
- For each accepted sample it takes taps x0..x3 and desired sample d, and computes the filter output y = sum(w_i*x_i) and the error e = d - y.
- It then updates the four coefficients in place by LMS: w_i += (e*x_i) >>> MU_SHIFT.
- It uses one time-multiplexed multiplier sequenced by an FSM, with a valid/ready handshake to the sample source.

Parameters:
- XW, 8: tap and desired-sample width, signed.
- WW, 16: coefficient width, signed, Q(WW-FRAC).FRAC.
- FRAC, 8: fractional bits of the coefficients.
- MU_SHIFT, 4: step size, mu = 2^-MU_SHIFT, applied to e*x_i in coefficient LSBs.
- LEAK_SHIFT, 8: leakage shift; used only with LMS_LEAK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample strobe; x0..x3 and d valid
- in_ready  out  1  block idle and able to accept a sample
- x0,x1,x2,x3  in  XW  signed taps, x0 newest
- d  in  XW  signed desired sample
- adapt_en  in  1  sampled on accept; 0 means filter only, coefficients held
- out_valid  out  1  one-cycle pulse; y and e valid
- y  out  WW  signed filter output, integer units
- e  out  WW  signed error
- w0,w1,w2,w3  out  WW  current coefficients, registered

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, y=0, e=0, w0..w3=0.
  - Accumulator and tap index are cleared; any in-flight sample is discarded.
- FSM states: IDLE, MAC, ERR, UPD, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture x0..x3, d and adapt_en, clear acc, set idx=0, go to MAC. in_valid in any other state is ignored; the sample is not latched.
  - MAC (4 cycles, idx 0..3): acc += x_idx*w_idx. The product is full precision (XW+WW bits); acc is XW+WW+2 bits. After idx 3, go to ERR.
  - ERR (1 cycle):
    - y <= sat_WW(acc >>> FRAC), arithmetic shift, floor.
    - e <= sat_WW(d - y_new), where d is sign-extended.
    - If adapt_en was captured as 1, go to UPD with idx=0; otherwise go to DONE.
  - UPD (4 cycles, idx 0..3): w_idx <= sat_WW(w_idx + ((e*x_idx) >>> MU_SHIFT)). After idx 3, go to DONE.
  - DONE: out_valid=1 for exactly 1 cycle, then IDLE.
- Latency, counted from the accepting edge:
  - out_valid is high in the cycle after edge 9 with adaptation, after edge 5 without.
  - Throughput: one sample per 11 cycles (adapt) or 7 cycles (no adapt).
- y and e hold their values until the next ERR. w0..w3 change only in UPD or on reset.
- Saturation clamps to [-2^(WW-1), 2^(WW-1)-1]; no wrap-around anywhere.
- The upstream delay line must advance only on the accept handshake (clock-enable = in_valid&&in_ready), so taps stay aligned with d.

Optional Feature:
- Macro: LMS_LEAK_EN.
- Defined: the UPD update becomes w_idx <= sat_WW(w_idx - (w_idx >>> LEAK_SHIFT) + ((e*x_idx) >>> MU_SHIFT)) (leaky LMS). Timing is unchanged.
- Undefined: standard LMS as above; LEAK_SHIFT is unused.

Decomposition:
- Shared package lms_pkg holds:
  - FSM state enum.
  - Width constants XW, WW, FRAC, ACCW.
  - A saturating-resize function sat_ww.
- One natural sub-module, lms_sat_add: a signed add of two WW+ operands with a clamp to WW. It is used by both the error computation and the coefficient update.

Test Plan:
1. Reset, then x=(10,20,30,40), d=64, adapt_en=1, MU_SHIFT=4 -> y=0, e=64; w=(40,80,120,160); out_valid 9 cycles after accept.
2. Repeat the same sample -> acc=12000, y=46, e=18; w=(51,102,153,205).
3. adapt_en=0, any sample -> out_valid 5 cycles after accept; w0..w3 unchanged; in_valid pulses while busy are ignored and in_ready stays low until IDLE.
4. Preload weights via repeated x=(-128,-128,-128,-128), d=127 -> w_i clamp at -32768, never wrap positive; y and e clamp at ±32767/-32768.
5. Assert rst during UPD idx=2 -> immediately y=e=w_i=0, out_valid=0, in_ready=1; the next sample proceeds normally.
6. Build with LMS_LEAK_EN, LEAK_SHIFT=8, w0=256, e=0 -> w0 becomes 255 after one update; without the macro w0 stays 256.
